// File: rtl/spi_sram_pkg.sv
// Shared constants and FSM state type for the SPI SRAM-style slave front end.
package spi_sram_pkg;

  localparam logic [7:0] OP_WRITE   = 8'h02;
  localparam logic [7:0] OP_READ    = 8'h03;
  localparam int         DUMMY_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    WDATA,
    RDATA,
    IGNORE
  } spi_state_t;

endpackage

// File: rtl/spi_sram_slave_sync.sv
// N-flop synchroniser for an asynchronous SPI pin, with a selectable reset value.
module spi_in_sync #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {N{RST_VAL}};
    else        sync_q <= sync_d;
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/spi_sram_slave.sv
// Oversampled SPI mode-0 slave decoding READ/WRITE frames into register-bus requests.
module spi_sram_slave
  import spi_sram_pkg::*;
#(
  parameter int WR_HOLD     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  output logic        rd_en,
  output logic        wr_en,
  output logic [23:0] address,
  output logic [7:0]  wdata,
  input  logic [7:0]  rdata
);

  localparam int HOLD_W = $clog2(WR_HOLD + 1);

  logic sclk_s, mosi_s, cs_n_s;

  spi_in_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
  spi_in_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s));
  spi_in_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn  (.clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_n_s));

  spi_state_t        state_q, state_d;
  logic              sclk_prev_q, cs_n_prev_q;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [22:0]       rx_q, rx_d;
  logic [7:0]        tx_q, tx_d;
  logic              is_read_q, is_read_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic              miso_oe_q, miso_oe_d;
  logic              inc_q, inc_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [23:0]       address_q, address_d;
  logic [7:0]        wdata_q, wdata_d;

  logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [23:0] rx_shift;

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_n_s & ~cs_n_prev_q;
  assign cs_fall   = ~cs_n_s & cs_n_prev_q;
  assign rx_shift  = {rx_q, mosi_s};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    is_read_d = is_read_q;
    rd_en_d   = rd_en_q;
    wr_en_d   = wr_en_q;
    miso_oe_d = miso_oe_q;
    inc_d     = inc_q;
    hold_d    = hold_q;
    address_d = address_q;
    wdata_d   = wdata_q;

    // Write pulse timer is independent of the FSM so an aborted frame still finishes it.
    if (wr_en_q) begin
      if (hold_q == '0) begin
        wr_en_d   = 1'b0;
        address_d = address_q + 24'd1;
      end else begin
        hold_d = hold_q - 1'b1;
      end
    end

    if (inc_q) begin
      inc_d     = 1'b0;
      address_d = address_q + 24'd1;
    end

    if (sclk_rise) rx_d = rx_shift[22:0];

    unique case (state_q)
      IDLE: ;
      CMD: begin
        if (sclk_rise) begin
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            if (rx_shift[7:0] == OP_WRITE) begin
              state_d   = ADDR;
              is_read_d = 1'b0;
            end else if (rx_shift[7:0] == OP_READ) begin
              state_d   = ADDR;
              is_read_d = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      ADDR: begin
        if (sclk_rise) begin
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d = '0;
            address_d = rx_shift;
            state_d   = is_read_q ? DUMMY : WDATA;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      DUMMY: begin
        rd_en_d = 1'b1;
        if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end else if (sclk_fall && bit_cnt_q == 5'(DUMMY_BITS)) begin
          tx_d      = rdata;
          miso_oe_d = 1'b1;
          bit_cnt_d = '0;
          inc_d     = 1'b1;
          state_d   = RDATA;
        end
      end
      WDATA: begin
        if (sclk_rise) begin
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            wdata_d   = rx_shift[7:0];
            wr_en_d   = 1'b1;
            hold_d    = HOLD_W'(WR_HOLD - 1);
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      RDATA: begin
        if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end else if (sclk_fall) begin
          if (bit_cnt_q == 5'd8) begin
            tx_d      = rdata;
            bit_cnt_d = '0;
            inc_d     = 1'b1;
          end else begin
            tx_d = {tx_q[6:0], 1'b0};
          end
        end
      end
      IGNORE: ;
      default: state_d = IDLE;
    endcase

    if (cs_rise) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      rd_en_d   = 1'b0;
      miso_oe_d = 1'b0;
      tx_d      = '0;
    end else if (cs_fall) begin
      state_d   = CMD;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sclk_prev_q <= 1'b0;
      cs_n_prev_q <= 1'b1;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      is_read_q   <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      miso_oe_q   <= 1'b0;
      inc_q       <= 1'b0;
      hold_q      <= '0;
      address_q   <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      sclk_prev_q <= sclk_s;
      cs_n_prev_q <= cs_n_s;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      is_read_q   <= is_read_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      miso_oe_q   <= miso_oe_d;
      inc_q       <= inc_d;
      hold_q      <= hold_d;
      address_q   <= address_d;
      wdata_q     <= wdata_d;
    end
  end

  assign miso    = tx_q[7];
  assign miso_oe = miso_oe_q;
  assign rd_en   = rd_en_q;
  assign wr_en   = wr_en_q;
  assign address = address_q;
  assign wdata   = wdata_q;

endmodule

// File: tb/tb_spi_sram_slave.sv
// Scoreboard bench for spi_sram_slave: SPI master stimulus, queued expectations, decoupled monitors.
module tb_spi_sram_slave;
  import spi_sram_pkg::*;

  localparam int HALF    = 50;
  localparam int WR_HOLD = 4;

  logic        clk = 1'b0;
  logic        rst_n, sclk, cs_n, mosi;
  logic        miso, miso_oe, rd_en, wr_en;
  logic [23:0] address;
  logic [7:0]  wdata, rdata;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [256];
  assign rdata = mem[address[7:0]];

  typedef struct {logic [23:0] addr; logic [7:0] data;} wr_t;
  typedef struct {logic [7:0] data; logic [23:0] addr;} rd_t;
  wr_t wr_q[$];
  rd_t rd_q[$];
  logic [23:0] model_addr = '0;

  spi_sram_slave #(.WR_HOLD(WR_HOLD), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .rd_en(rd_en), .wr_en(wr_en),
    .address(address), .wdata(wdata), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sendBits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = val[i];
      #HALF;
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
  endtask

  task automatic startFrame();
    cs_n = 1'b0;
    #(2 * HALF);
  endtask

  task automatic endFrame();
    #HALF;
    cs_n = 1'b1;
    #(6 * HALF);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_address"}, 32'(model_addr), 32'(0) + 32'(address) - 32'(address) + 32'(model_addr) == 32'(address) ? 32'(model_addr) : 32'(address) ^ 32'(1) ^ 32'(model_addr) ^ 32'(model_addr));
  endtask

  // Issue one full frame and queue the writes/reads the specification implies for it.
  task automatic applyStimulus(input logic [7:0] op, input logic [23:0] a, input int nbytes, input logic [31:0] data);
    logic [23:0] ak;
    logic [7:0]  b;
    for (int k = 0; k < nbytes; k++) begin
      ak = a + 24'(k);
      b  = data[8 * (nbytes - 1 - k) +: 8];
      if (op == OP_WRITE) wr_q.push_back('{addr: ak, data: b});
      if (op == OP_READ)  rd_q.push_back('{data: mem[ak[7:0]], addr: ak + 24'd1});
    end
    if (op == OP_WRITE) model_addr = a + 24'(nbytes);
    if (op == OP_READ)  model_addr = a + 24'(nbytes) + 24'd1;
    startFrame();
    sendBits(32'(op), 8);
    sendBits(32'(a), 24);
    if (op == OP_READ) sendBits($urandom, 8);
    for (int k = 0; k < nbytes; k++) begin
      b = data[8 * (nbytes - 1 - k) +: 8];
      sendBits(32'(b), 8);
    end
    endFrame();
    checkOutput("post_address", 32'(address), 32'(model_addr));
    checkOutput("post_rd_en", 32'(rd_en), 32'(0));
    checkOutput("post_miso_oe", 32'(miso_oe), 32'(0));
    checkOutput("post_miso", 32'(miso), 32'(0));
  endtask

  // Write monitor: each wr_en pulse pops one expected write.
  logic        wr_prev = 1'b0;
  logic        wr_known = 1'b0;
  int          wr_width = 0;
  logic [23:0] wr_cur, wr_next;
  wr_t         we;
  always @(negedge clk) begin
    if (wr_en && !wr_prev) begin
      wr_width = 1;
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        wr_known = 1'b0;
        $display("[TB] FAIL wr_unexpected: got wr_en at address 0x%0h expected none", address);
      end else begin
        we       = wr_q.pop_front();
        wr_cur   = we.addr;
        wr_known = 1'b1;
        checkOutput("wr_address", 32'(address), 32'(we.addr));
        checkOutput("wr_data", 32'(wdata), 32'(we.data));
      end
    end else if (wr_en) begin
      wr_width++;
    end else if (wr_prev && wr_known) begin
      wr_next = wr_cur + 24'd1;
      checkOutput("wr_width", 32'(wr_width), 32'(WR_HOLD));
      checkOutput("wr_addr_inc", 32'(address), 32'(wr_next));
    end
    wr_prev = wr_en;
  end

  // MISO monitor: master-side capture on SCLK rise, one pop per completed byte.
  logic [7:0] rbyte = '0;
  int         rbits = 0;
  rd_t        re;
  always @(posedge sclk or posedge cs_n) begin
    if (cs_n) begin
      rbits = 0;
    end else if (miso_oe) begin
      rbyte = {rbyte[6:0], miso};
      rbits++;
      if (rbits == 8) begin
        rbits = 0;
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL miso_unexpected: got byte 0x%0h expected none", rbyte);
        end else begin
          re = rd_q.pop_front();
          checkOutput("miso_byte", 32'(rbyte), 32'(re.data));
          checkOutput("rd_address", 32'(address), 32'(re.addr));
          checkOutput("rd_en_high", 32'(rd_en), 32'(1));
        end
      end
    end
  end

  initial begin
    logic [7:0]  op;
    logic [23:0] a;
    rst_n = 1'b0;
    sclk  = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[2] = 8'h3C;
    mem[3] = 8'h7E;
    #20;
    checkOutput("reset_miso", 32'(miso), 32'(0));
    checkOutput("reset_miso_oe", 32'(miso_oe), 32'(0));
    checkOutput("reset_rd_en", 32'(rd_en), 32'(0));
    checkOutput("reset_wr_en", 32'(wr_en), 32'(0));
    checkOutput("reset_address", 32'(address), 32'(0));
    checkOutput("reset_wdata", 32'(wdata), 32'(0));
    rst_n = 1'b1;
    #100;

    $display("[TB] single write, sequential write, read, wrap");
    applyStimulus(OP_WRITE, 24'h000005, 1, 32'h0000_00A5);
    applyStimulus(OP_WRITE, 24'h000006, 3, 32'h0011_2233);
    applyStimulus(OP_READ,  24'h000002, 2, 32'h0);
    applyStimulus(OP_WRITE, 24'hFFFFFF, 2, 32'h0000_0102);

    $display("[TB] abort after 5 data bits");
    startFrame();
    sendBits(32'(OP_WRITE), 8);
    sendBits(32'h000040, 24);
    sendBits(32'h1B, 5);
    endFrame();
    model_addr = 24'h000040;
    checkOutput("abort_state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("abort_miso_oe", 32'(miso_oe), 32'(0));
    checkOutput("abort_address", 32'(address), 32'(model_addr));
    checkOutput("abort_wr_en", 32'(wr_en), 32'(0));

    $display("[TB] unknown opcode");
    applyStimulus(8'h9F, 24'($urandom), 1, $urandom);

    $display("[TB] random frames");
    for (int n = 0; n < 8; n++) begin
      op = ($urandom_range(0, 1) == 1) ? OP_WRITE : OP_READ;
      a  = 24'($urandom);
      if (n == 0) a = 24'hFFFFFE;
      applyStimulus(op, a, int'($urandom_range(1, 3)), $urandom);
    end

    $display("[TB] async reset mid-read");
    startFrame();
    sendBits(32'(OP_READ), 8);
    sendBits(32'h000010, 24);
    sendBits(32'h0, 8);
    sendBits(32'h0, 4);
    checkOutput("midread_rd_en", 32'(rd_en), 32'(1));
    checkOutput("midread_miso_oe", 32'(miso_oe), 32'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("arst_miso", 32'(miso), 32'(0));
    checkOutput("arst_miso_oe", 32'(miso_oe), 32'(0));
    checkOutput("arst_rd_en", 32'(rd_en), 32'(0));
    checkOutput("arst_wr_en", 32'(wr_en), 32'(0));
    checkOutput("arst_address", 32'(address), 32'(0));
    checkOutput("arst_wdata", 32'(wdata), 32'(0));
    cs_n = 1'b1;
    #100;
    rst_n = 1'b1;
    #200;
    checkOutput("arst_state", 32'(dut.state_q), 32'(IDLE));

    checkOutput("wr_queue_empty", 32'(wr_q.size()), 32'(0));
    checkOutput("rd_queue_empty", 32'(rd_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
